// File: rtl/uart_rx_block_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_block_if
// Purpose  : Bundles the serial input and the block-level outputs of the
//            UART block receiver.
// Ports    : rx         - serial line, idle high
//            data       - last complete 128-bit block
//            data_valid - one-cycle pulse when data has been updated
//            busy       - a block is partially received
//            frame_err  - sticky bad-stop-bit flag
// Modports : master - drives rx, observes the receiver outputs
//            slave  - the receiver itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_block_if;
  logic         rx;
  logic [127:0] data;
  logic         data_valid;
  logic         busy;
  logic         frame_err;

  modport master (output rx, input data, data_valid, busy, frame_err);
  modport slave  (input rx, output data, data_valid, busy, frame_err);
endinterface
`default_nettype wire

// File: rtl/uart_rx_block.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_block
// Purpose  : UART receiver (1 start, 8 data LSB first, 2 stop, idle high)
//            that reassembles one 128-bit block from 16 consecutive bytes.
//            The first byte received lands in data[127:120].
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-low reset
//            bus   - uart_rx_block_if.slave (rx, data, data_valid, busy,
//                    frame_err)
// Options  : RX_TIMEOUT_EN - when defined, a partial block is discarded
//            after TIMEOUT_BITS bit times of inter-byte silence.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_block #(
  parameter int CLOCK_PER_BIT = 10417,
  parameter int HALF_BIT      = CLOCK_PER_BIT / 2,
  parameter int TIMEOUT_BITS  = 40
) (
  input  wire logic      clk,
  input  wire logic      reset,
  uart_rx_block_if.slave bus
);

  localparam int CNT_W = $clog2(CLOCK_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLOCK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [119:0]     staging_q, staging_d;
  logic [127:0]     data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             rx_s;
  logic             start_edge;
  logic [6:0]       slot_lsb;

  // Byte n of the block occupies staging bits [119-8n -: 8].
  assign slot_lsb = {4'd14 - byte_cnt_q, 3'b000};
  assign sync_d   = {sync_q[0], bus.rx};
  assign rx_s     = sync_q[1];

`ifdef RX_TIMEOUT_EN
  localparam int GAP_LIMIT = TIMEOUT_BITS * CLOCK_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIMIT - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  logic unused_timeout_bits;
  assign unused_timeout_bits = (TIMEOUT_BITS > 0);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    staging_d    = staging_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    // A start is only accepted once the line has been seen high, so a line
    // stuck low after a framing error cannot retrigger reception.
    armed_d      = armed_q | rx_s;
    start_edge   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (!rx_s && armed_q) begin
          start_edge = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d            = '0;
          shift_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            if (byte_cnt_q == 4'd15) begin
              data_d       = {staging_q, shift_q};
              data_valid_d = 1'b1;
              frame_err_d  = 1'b0;
              byte_cnt_d   = '0;
            end else begin
              staging_d[slot_lsb +: 8] = shift_q;
              byte_cnt_d               = byte_cnt_q + 4'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            armed_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef RX_TIMEOUT_EN
    // Silence between bytes of a partial block; any start edge restarts it.
    gap_d = '0;
    if (state_q == IDLE && byte_cnt_q != 4'd0 && !start_edge) begin
      if (gap_q == GAP_LAST) begin
        byte_cnt_d = '0;
        staging_d  = '0;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      staging_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      staging_q    <= staging_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (byte_cnt_q != 4'd0) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_block.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_block
// Purpose  : Self-checking bench for uart_rx_block at 16 clocks per bit.
//            A byte-level model (list of received bytes, block assembly,
//            sticky error flag) predicts every completed block.
// Options  : RX_TIMEOUT_EN - model follows the inter-byte timeout when set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_block;
  localparam int C  = 16;
  localparam int H  = 8;
  localparam int TO = 40;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  uart_rx_block_if bus ();

  uart_rx_block #(.CLOCK_PER_BIT(C), .HALF_BIT(H), .TIMEOUT_BITS(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]   m_buf [16];
  int           m_cnt  = 0;
  logic         m_ferr = 1'b0;
  logic [127:0] exp_q [$];
  logic [127:0] got_q [$];

  function automatic logic [127:0] pack_block();
    logic [127:0] blk;
    for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = m_buf[i];
    return blk;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_cnt  = 0;
      m_ferr = 1'b1;
    end else begin
      m_buf[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 16) begin
        exp_q.push_back(pack_block());
        m_cnt  = 0;
        m_ferr = 1'b0;
      end
    end
  endfunction

  function automatic void model_idle(input int cycles);
`ifdef RX_TIMEOUT_EN
    if (m_cnt != 0 && cycles >= TO * C) m_cnt = 0;
`else
    if (cycles < 0) m_cnt = 0;
`endif
  endfunction

  // Monitor: collects blocks and checks pulse width / data stability.
  logic [127:0] prev_data;
  logic         prev_valid;
  always @(negedge clk) begin
    if (!reset) begin
      prev_data  = '0;
      prev_valid = 1'b0;
    end else begin
      if (bus.data !== prev_data) begin
        tests++;
        if (bus.data_valid !== 1'b1) begin
          fails++;
          $display("FAIL data_hold: data changed to %h with data_valid=%b, required 1", bus.data, bus.data_valid);
        end
        prev_data = bus.data;
      end
      if (bus.data_valid === 1'b1) begin
        got_q.push_back(bus.data);
        tests++;
        if (prev_valid === 1'b1) begin
          fails++;
          $display("FAIL valid_pulse: data_valid high for 2+ cycles, required 1");
        end
      end
      prev_valid = bus.data_valid;
    end
  end

  task automatic drive(input logic val, input int n);
    bus.rx = val;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int idle);
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(b[i], C);
    drive(stop_ok, C);
    drive(1'b1, C);
    if (idle > 0) drive(1'b1, idle);
    model_byte(b, stop_ok);
    model_idle(idle);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    reset  = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.data !== 128'h0) begin fails++; $display("FAIL reset_data: got %h required 0", bus.data); end
    tests++; if (bus.data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", bus.data_valid); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b required 0", bus.frame_err); end
    #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b required 0", bus.busy); end
  endtask

  task automatic test_incrementing();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, int'($urandom_range(0, 20)));
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL incr_count: got %0d blocks required %0d", got_q.size(), exp_q.size());
    end else begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL incr_model: got %h required %h", got_q[0], exp_q[0]); end
      tests++; if (got_q[0] !== 128'h000102030405060708090A0B0C0D0E0F) begin fails++; $display("FAIL incr_data: got %h required 000102030405060708090a0b0c0d0e0f", got_q[0]); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL incr_busy: got %b required 0", bus.busy); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL incr_ferr: got %b required 0", bus.frame_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1, 0);
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL b2b_count: got %0d blocks required 1", got_q.size());
    end else begin
      tests++; if (got_q[0] !== {16{8'hA5}}) begin fails++; $display("FAIL b2b_data: got %h required all a5", got_q[0]); end
    end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_busy: got %b required 0", bus.busy); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 10)));
    drive(1'b0, 4);
    drive(1'b1, 3 * C);
    tests++; if (bus.busy !== (m_cnt != 0)) begin fails++; $display("FAIL glitch_busy: got %b required %b", bus.busy, (m_cnt != 0)); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL glitch_valid: got %0d blocks required 0", got_q.size()); end
    for (int i = 0; i < 13; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 10)));
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL glitch_count: got %0d blocks required %0d", got_q.size(), exp_q.size());
    end else begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL glitch_data: got %h required %h", got_q[0], exp_q[0]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_frame_error();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 0);
    send_byte(8'($urandom), 1'b0, 0);
    tests++; if (bus.frame_err !== m_ferr) begin fails++; $display("FAIL ferr_set: got %b required %b", bus.frame_err, m_ferr); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ferr_busy: got %b required 0", bus.busy); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL ferr_valid: got %0d blocks required 0", got_q.size()); end
    drive(1'b1, 3 * C);
    for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1, int'($urandom_range(0, 8)));
    tests++;
    if (got_q.size() != 1) begin
      fails++; $display("FAIL ferr_count: got %0d blocks required 1", got_q.size());
    end else begin
      tests++; if (got_q[0] !== {128{1'b1}}) begin fails++; $display("FAIL ferr_data: got %h required all ff", got_q[0]); end
    end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL ferr_clear: got %b required 0", bus.frame_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midblock();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom), 1'b1, 0);
    #2 reset = 1'b0;
    #1;
    tests++; if (bus.data !== 128'h0) begin fails++; $display("FAIL rst_data: got %h required 0", bus.data); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    tests++; if (bus.frame_err !== 1'b0 || bus.data_valid !== 1'b0) begin
      fails++; $display("FAIL rst_flags: got ferr=%b valid=%b required 0 0", bus.frame_err, bus.data_valid);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    m_cnt = 0; m_ferr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 20)));
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL rst_count: got %0d blocks required %0d", got_q.size(), exp_q.size());
    end else begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL rst_block: got %h required %h", got_q[0], exp_q[0]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random_blocks();
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 3 * C)));
    tests++;
    if (got_q.size() != 2 || exp_q.size() != 2) begin
      fails++; $display("FAIL rand_count: got %0d blocks required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_block%0d: got %h required %h", i, got_q[i], exp_q[i]); end
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    logic [7:0]   b [3];
    logic [127:0] exp_c;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      send_byte(b[i], 1'b1, 0);
    end
    drive(1'b1, 700);
    model_idle(700);
    for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b1, 0);
`ifdef RX_TIMEOUT_EN
    exp_c = {16{8'h11}};
`else
    exp_c = {b[0], b[1], b[2], {13{8'h11}}};
`endif
    tests++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      fails++; $display("FAIL tmo_count: got %0d blocks required %0d", got_q.size(), exp_q.size());
    end else begin
      tests++; if (got_q[0] !== exp_q[0]) begin fails++; $display("FAIL tmo_model: got %h required %h", got_q[0], exp_q[0]); end
      tests++; if (got_q[0] !== exp_c) begin fails++; $display("FAIL tmo_data: got %h required %h", got_q[0], exp_c); end
    end
    tests++; if (bus.busy !== (m_cnt != 0)) begin fails++; $display("FAIL tmo_busy: got %b required %b", bus.busy, (m_cnt != 0)); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midblock();
    test_random_blocks();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_rx_block.md
Name: uart_rx_block

Overview:
- UART receiver that reassembles one 128-bit AES block from 16 consecutive serial bytes.
- Mirror of the block transmitter on the same link: 1 start bit (0), 8 data bits LSB first, 2 stop bits (1), idle high.
- First byte received is data[127:120]; last byte received is data[7:0].
- Sits between the board RX pin and the AES core's block input.

Parameters:
- CLOCK_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud).
- HALF_BIT, CLOCK_PER_BIT/2 (integer division), cycles from start-bit falling edge to the start-bit sample point.
- TIMEOUT_BITS, 40, inter-byte gap limit in bit times (used only with RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  128  last complete received block.
- data_valid  output  1  one-cycle pulse when data has been updated.
- busy  output  1  high while a block is partially received (byte_cnt != 0 or state != IDLE).
- frame_err  output  1  sticky; set on a bad stop bit, cleared when the next block completes.

Behaviour:
- Reset (reset=0, asynchronous) sets the following:
  - data=0, data_valid=0, busy=0, frame_err=0.
  - state=IDLE, byte_cnt=0, bit_cnt=0, clock counter=0.
  - Both synchronizer flops = 1.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- IDLE:
  - Waits for rx_s=0 (start edge), then clears the counter and goes to START.
  - Also requires rx_s to have been 1 at least once since the last frame error ("armed" flag).
- START:
  - At counter==HALF_BIT-1, samples rx_s.
  - rx_s=1: false start; return to IDLE. byte_cnt is unchanged.
  - rx_s=0: clear the counter and go to DATA.
- DATA:
  - At each counter==CLOCK_PER_BIT-1, samples rx_s into shift[bit_cnt], LSB first, then clears the counter.
  - After bit_cnt=7, go to STOP.
- STOP:
  - At counter==CLOCK_PER_BIT-1, samples the first stop bit.
  - Stop bit = 1: store the byte into a 120-bit staging register at slot byte_cnt.
    - If byte_cnt<15: byte_cnt+1, go to IDLE.
    - If byte_cnt==15: on the same edge, data <= {staging, byte}, data_valid=1 for exactly that next cycle, frame_err<=0, byte_cnt<=0, go to IDLE.
  - Stop bit = 0: frame_err<=1, byte and partial block discarded, byte_cnt<=0, armed<=0, go to IDLE.
- The second stop bit is not checked; it falls in IDLE as line-high time.
- Latency: data_valid rises 1 clk after the stop-bit sample of byte 15, about 9.5 bit times after that byte's start edge plus 2 synchronizer cycles.
- data holds its value between blocks. It never changes except on a completed block.
- State encoding: 2 bits (IDLE, START, DATA, STOP). Unused encodings return to IDLE.
- A start edge arriving during the second stop bit of the previous byte is accepted normally (back-to-back frames).
- Reset mid-byte or mid-block: all progress is lost and the outputs return to their reset values immediately.
- Counter width: ceil(log2(CLOCK_PER_BIT)) bits, 14 at the default. The counter never wraps past CLOCK_PER_BIT-1.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - While byte_cnt!=0 and state==IDLE, a gap counter counts clk cycles.
  - If the gap reaches TIMEOUT_BITS*CLOCK_PER_BIT, byte_cnt<=0 and the staging register is discarded.
  - frame_err is unchanged and no data_valid is issued.
  - The gap counter clears on every start edge.
- Not defined: no gap counter. A partial block waits indefinitely for its remaining bytes.

Test Plan:
All cases use CLOCK_PER_BIT=16 (HALF_BIT=8).
- Reset then 16 clean frames of bytes 0x00..0x0F -> one data_valid pulse; data=128'h000102030405060708090A0B0C0D0E0F; busy low after; frame_err=0.
- Block of 16x 0xA5 sent back-to-back, next frame starts immediately after the 2nd stop bit -> data=128'hA5A5...A5 (all 16 bytes); no byte lost.
- Glitch: rx low 4 cycles, then high -> no state advance past START; byte_cnt unchanged; no data_valid.
- Byte 5 sent with stop bit 0 -> frame_err=1, byte_cnt=0, no data_valid. After line idle high, 16 good bytes 0xFF -> data all 1s, data_valid pulse, frame_err=0.
- Assert reset low for 1 cycle after byte 9 -> all outputs 0 immediately. Previous data is lost; the next full 16-byte block is received correctly.
- RX_TIMEOUT_EN defined, TIMEOUT_BITS=40: send 3 bytes, idle 700 cycles, then 16 bytes 0x11 -> exactly one data_valid, data=all 0x11. Without the macro, the same stimulus yields data_valid after the 13th 0x11 byte.
